uart_parity_engine: RTL and testbench

UART_PARITY_ENGINE -- requirements
Module: uart_parity_engine

---
 rtl/uart_parity_engine.sv | 169 ++++++++++++++++
 tb/tb_uart_parity_engine.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_engine.sv
// UART parity engine.
// Transmit side: a two-state handshake generator. It captures a frame and its
// parity settings, then holds the parity bit until the serializer acknowledges it.
// Receive side: an independent checker. It compares each sampled parity bit
// against the expected value and keeps a sticky flag and a saturating error count.

module uart_parity_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PAR_EN,
  input  logic [1:0]               PAR_MODE,
  input  logic [DATA_WIDTH-1:0]    TX_DATA,
  input  logic                     TX_VALID,
  output logic                     TX_READY,
  output logic                     PAR_BIT,
  output logic                     PAR_VALID,
  input  logic                     PAR_ACK,
  input  logic [DATA_WIDTH-1:0]    RX_DATA,
  input  logic                     RX_PAR,
  input  logic                     RX_SAMPLE,
  input  logic                     ERR_CLR,
  output logic                     PAR_ERR_STRB,
  output logic                     PAR_ERR,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } gen_state_t;

  localparam logic [1:0] MODE_EVEN  = 2'b00;
  localparam logic [1:0] MODE_ODD   = 2'b01;
  localparam logic [1:0] MODE_MARK  = 2'b10;

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  // Shared parity rule for both paths: disabled parity always yields 0.
  function automatic logic calc_parity(
    input logic [DATA_WIDTH-1:0] data,
    input logic                  en,
    input logic [1:0]            mode
  );
    logic p;
    p = 1'b0;
    if (en) begin
      case (mode)
        MODE_EVEN: p = ^data;
        MODE_ODD:  p = ~(^data);
        MODE_MARK: p = 1'b1;
        default:   p = 1'b0;
      endcase
    end
    return p;
  endfunction

  // Generator state and the frame settings captured at accept time.
  gen_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_mode_q, par_mode_d;

  // Checker state.
  logic                     err_strb_q, err_strb_d;
  logic                     par_err_q, par_err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     rx_mismatch;

  // Generator state register; reset drops any pending bit immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      par_en_q   <= 1'b0;
      par_mode_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
    end
  end

  // Generator next state: capture on accept in IDLE; release on ACK in HOLD.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    TX_READY   = 1'b0;
    PAR_VALID  = 1'b0;
    case (state_q)
      IDLE: begin
        TX_READY = 1'b1;
        if (TX_VALID) begin
          tx_data_d  = TX_DATA;
          par_en_d   = PAR_EN;
          par_mode_d = PAR_MODE;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        PAR_VALID = 1'b1;
        if (PAR_ACK) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The parity bit depends only on the captured settings, so it stays stable while held.
  always_comb begin
    PAR_BIT = calc_parity(tx_data_q, par_en_q, par_mode_q);
  end

  // Receive mismatch detection; it uses the live mode and enable of the sample cycle.
  always_comb begin
    rx_mismatch = 1'b0;
    if (RX_SAMPLE && PAR_EN) begin
      rx_mismatch = (RX_PAR != calc_parity(RX_DATA, 1'b1, PAR_MODE));
    end
  end

  // Checker next state: a new error beats a concurrent clear and restarts the count at 1.
  always_comb begin
    err_strb_d = rx_mismatch;
    par_err_d  = par_err_q;
    err_cnt_d  = err_cnt_q;
    if (rx_mismatch) begin
      par_err_d = 1'b1;
      if (ERR_CLR) begin
        err_cnt_d = CNT_ONE;
      end else if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end else if (ERR_CLR) begin
      par_err_d = 1'b0;
      err_cnt_d = '0;
    end
  end

  // Checker registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_strb_q <= 1'b0;
      par_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_strb_q <= err_strb_d;
      par_err_q  <= par_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Drive the checker outputs straight from the flops.
  always_comb begin
    PAR_ERR_STRB = err_strb_q;
    PAR_ERR      = par_err_q;
    ERR_CNT      = err_cnt_q;
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
// Testbench for uart_parity_engine.
// Two instances share all control inputs: an 8-bit/8-bit-counter build and a
// 7-bit/2-bit-counter build. A behavioural model predicts both instances every cycle.

module tb_uart_parity_engine;

  localparam int WA = 8;
  localparam int CA = 8;
  localparam int WB = 7;
  localparam int CB = 2;
  localparam int MAX_A = (1 << CA) - 1;
  localparam int MAX_B = (1 << CB) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       par_en = 1'b0;
  logic [1:0] par_mode = 2'b00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       par_ack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_par = 1'b0;
  logic       rx_sample = 1'b0;
  logic       err_clr = 1'b0;

  logic          tx_ready_a, par_bit_a, par_valid_a, strb_a, err_a;
  logic [CA-1:0] cnt_a;
  logic          tx_ready_b, par_bit_b, par_valid_b, strb_b, err_b;
  logic [CB-1:0] cnt_b;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  // Model state
  logic m_hold, m_bit_a, m_bit_b, m_strb_a, m_strb_b, m_err_a, m_err_b;
  int   m_cnt_a, m_cnt_b;

  always #5 clk = ~clk;

  uart_parity_engine #(.DATA_WIDTH(WA), .ERR_CNT_WIDTH(CA)) dut_a (
    .CLK(clk), .RST(rst_n), .PAR_EN(par_en), .PAR_MODE(par_mode),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready_a),
    .PAR_BIT(par_bit_a), .PAR_VALID(par_valid_a), .PAR_ACK(par_ack),
    .RX_DATA(rx_data), .RX_PAR(rx_par), .RX_SAMPLE(rx_sample),
    .ERR_CLR(err_clr), .PAR_ERR_STRB(strb_a), .PAR_ERR(err_a), .ERR_CNT(cnt_a)
  );

  uart_parity_engine #(.DATA_WIDTH(WB), .ERR_CNT_WIDTH(CB)) dut_b (
    .CLK(clk), .RST(rst_n), .PAR_EN(par_en), .PAR_MODE(par_mode),
    .TX_DATA(tx_data[6:0]), .TX_VALID(tx_valid), .TX_READY(tx_ready_b),
    .PAR_BIT(par_bit_b), .PAR_VALID(par_valid_b), .PAR_ACK(par_ack),
    .RX_DATA(rx_data[6:0]), .RX_PAR(rx_par), .RX_SAMPLE(rx_sample),
    .ERR_CLR(err_clr), .PAR_ERR_STRB(strb_b), .PAR_ERR(err_b), .ERR_CNT(cnt_b)
  );

  // Parity from a population count of the low 'width' bits.
  function automatic logic model_parity(input int data, input int width,
                                        input logic en, input logic [1:0] mode);
    int ones;
    if (!en) return 1'b0;
    if (mode == 2'd2) return 1'b1;
    if (mode == 2'd3) return 1'b0;
    ones = $countones(data & ((1 << width) - 1));
    if (mode == 2'd0) return logic'(ones % 2);
    return logic'(1 - (ones % 2));
  endfunction

  function automatic logic model_mismatch(input int data, input int width,
                                          input logic par, input logic [1:0] mode);
    return par != model_parity(data, width, 1'b1, mode);
  endfunction

  function automatic int sat_inc(input int value, input int max);
    return (value < max) ? value + 1 : max;
  endfunction

  // Behavioural model of both instances, advanced on every clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= 1'b0; m_bit_a <= 1'b0; m_bit_b <= 1'b0;
      m_strb_a <= 1'b0; m_strb_b <= 1'b0; m_err_a <= 1'b0; m_err_b <= 1'b0;
      m_cnt_a <= 0; m_cnt_b <= 0;
    end else begin
      if (!m_hold && tx_valid) begin
        m_hold  <= 1'b1;
        m_bit_a <= model_parity(int'(tx_data), WA, par_en, par_mode);
        m_bit_b <= model_parity(int'(tx_data), WB, par_en, par_mode);
      end else if (m_hold && par_ack) begin
        m_hold <= 1'b0;
      end
      if (rx_sample && par_en && model_mismatch(int'(rx_data), WA, rx_par, par_mode)) begin
        m_strb_a <= 1'b1; m_err_a <= 1'b1;
        m_cnt_a  <= err_clr ? 1 : sat_inc(m_cnt_a, MAX_A);
      end else begin
        m_strb_a <= 1'b0;
        if (err_clr) begin m_err_a <= 1'b0; m_cnt_a <= 0; end
      end
      if (rx_sample && par_en && model_mismatch(int'(rx_data), WB, rx_par, par_mode)) begin
        m_strb_b <= 1'b1; m_err_b <= 1'b1;
        m_cnt_b  <= err_clr ? 1 : sat_inc(m_cnt_b, MAX_B);
      end else begin
        m_strb_b <= 1'b0;
        if (err_clr) begin m_err_b <= 1'b0; m_cnt_b <= 0; end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("m_tx_ready_a", 32'(tx_ready_a), 32'(!m_hold));
      checkOutput("m_par_valid_a", 32'(par_valid_a), 32'(m_hold));
      checkOutput("m_tx_ready_b", 32'(tx_ready_b), 32'(!m_hold));
      checkOutput("m_par_valid_b", 32'(par_valid_b), 32'(m_hold));
      if (m_hold) begin
        checkOutput("m_par_bit_a", 32'(par_bit_a), 32'(m_bit_a));
        checkOutput("m_par_bit_b", 32'(par_bit_b), 32'(m_bit_b));
      end
      checkOutput("m_strb_a", 32'(strb_a), 32'(m_strb_a));
      checkOutput("m_err_a", 32'(err_a), 32'(m_err_a));
      checkOutput("m_cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      checkOutput("m_strb_b", 32'(strb_b), 32'(m_strb_b));
      checkOutput("m_err_b", 32'(err_b), 32'(m_err_b));
      checkOutput("m_cnt_b", 32'(cnt_b), 32'(m_cnt_b));
    end
  end

  task automatic applyStimulus(input logic tv, input logic [7:0] td, input logic pe,
                               input logic [1:0] pm, input logic ack, input logic rs,
                               input logic [7:0] rd, input logic rp, input logic ec);
    tx_valid = tv; tx_data = td; par_en = pe; par_mode = pm; par_ack = ack;
    rx_sample = rs; rx_data = rd; rx_par = rp; err_clr = ec;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #12;
    // Reset values
    checkOutput("rst_tx_ready_a", 32'(tx_ready_a), 32'd1);
    checkOutput("rst_par_valid_a", 32'(par_valid_a), 32'd0);
    checkOutput("rst_par_bit_a", 32'(par_bit_a), 32'd0);
    checkOutput("rst_strb_a", 32'(strb_a), 32'd0);
    checkOutput("rst_err_a", 32'(err_a), 32'd0);
    checkOutput("rst_cnt_a", 32'(cnt_a), 32'd0);
    checkOutput("rst_tx_ready_b", 32'(tx_ready_b), 32'd1);
    checkOutput("rst_cnt_b", 32'(cnt_b), 32'd0);
    cmp_en = 1'b1;

    // Release reset and offer a frame at once: accepted on the first edge
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(1, 8'hA7, 1, 2'b00, 0, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("even_a7_valid", 32'(par_valid_a), 32'd1);
    checkOutput("even_a7_bit", 32'(par_bit_a), 32'd1);
    checkOutput("even_a7_ready", 32'(tx_ready_a), 32'd0);
    checkOutput("even_27_bit_b", 32'(par_bit_b), 32'd0);
    applyStimulus(0, 8'hA7, 1, 2'b00, 1, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("ack_valid", 32'(par_valid_a), 32'd0);
    checkOutput("ack_ready", 32'(tx_ready_a), 32'd1);

    // ACK while idle is ignored
    applyStimulus(0, 8'h00, 1, 2'b00, 1, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("idle_ack_ready", 32'(tx_ready_a), 32'd1);

    // Odd accept, then settings change while held
    applyStimulus(1, 8'hA7, 1, 2'b01, 0, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("odd_a7_bit", 32'(par_bit_a), 32'd0);
    checkOutput("odd_27_bit_b", 32'(par_bit_b), 32'd1);
    applyStimulus(0, 8'hA7, 1, 2'b00, 0, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("hold_mode_change_bit", 32'(par_bit_a), 32'd0);
    applyStimulus(1, 8'h01, 0, 2'b10, 0, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("hold_txvalid_bit", 32'(par_bit_a), 32'd0);
    checkOutput("hold_txvalid_valid", 32'(par_valid_a), 32'd1);
    applyStimulus(0, 8'h01, 1, 2'b00, 1, 0, 8'h00, 0, 0);
    stepCycle();
    applyStimulus(0, 8'h01, 1, 2'b00, 0, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("no_queue_valid", 32'(par_valid_a), 32'd0);

    // Even mismatch on 7-bit data 0x01
    applyStimulus(0, 8'h00, 1, 2'b00, 0, 1, 8'h01, 0, 0);
    stepCycle();
    checkOutput("rx_strb_b", 32'(strb_b), 32'd1);
    checkOutput("rx_err_b", 32'(err_b), 32'd1);
    checkOutput("rx_cnt_b", 32'(cnt_b), 32'd1);
    applyStimulus(0, 8'h00, 1, 2'b00, 0, 0, 8'h01, 0, 0);
    stepCycle();
    checkOutput("rx_strb_one_cycle", 32'(strb_b), 32'd0);
    applyStimulus(0, 8'h00, 0, 2'b00, 0, 1, 8'h01, 0, 0);
    stepCycle();
    checkOutput("rx_disabled_strb", 32'(strb_b), 32'd0);
    checkOutput("rx_disabled_cnt", 32'(cnt_b), 32'd1);

    // Clear, saturate, then clear together with a new error
    applyStimulus(0, 8'h00, 1, 2'b00, 0, 0, 8'h00, 0, 1);
    stepCycle();
    checkOutput("clr_err_b", 32'(err_b), 32'd0);
    checkOutput("clr_cnt_a", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 8'h00, 1, 2'b00, 0, 1, 8'h01, 0, 0);
      stepCycle();
    end
    checkOutput("sat_cnt_b", 32'(cnt_b), 32'd3);
    checkOutput("five_cnt_a", 32'(cnt_a), 32'd5);
    applyStimulus(0, 8'h00, 1, 2'b00, 0, 1, 8'h01, 0, 1);
    stepCycle();
    checkOutput("clr_err_win_cnt_b", 32'(cnt_b), 32'd1);
    checkOutput("clr_err_win_err_b", 32'(err_b), 32'd1);
    checkOutput("clr_err_win_strb_b", 32'(strb_b), 32'd1);

    // Mark and space modes
    applyStimulus(1, 8'h5A, 1, 2'b10, 0, 1, 8'h33, 0, 0);
    stepCycle();
    checkOutput("mark_bit_a", 32'(par_bit_a), 32'd1);
    checkOutput("mark_strb_a", 32'(strb_a), 32'd1);
    applyStimulus(0, 8'h00, 1, 2'b10, 1, 1, 8'h33, 1, 0);
    stepCycle();
    checkOutput("mark_ok_strb_a", 32'(strb_a), 32'd0);
    applyStimulus(1, 8'hFF, 1, 2'b11, 0, 1, 8'h33, 1, 0);
    stepCycle();
    checkOutput("space_bit_a", 32'(par_bit_a), 32'd0);
    checkOutput("space_strb_a", 32'(strb_a), 32'd1);
    applyStimulus(0, 8'h00, 1, 2'b11, 1, 1, 8'h33, 0, 0);
    stepCycle();
    checkOutput("space_ok_strb_a", 32'(strb_a), 32'd0);

    // Asynchronous reset in the middle of HOLD
    applyStimulus(1, 8'hA7, 1, 2'b00, 0, 0, 8'h00, 0, 0);
    stepCycle();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(par_valid_a), 32'd0);
    checkOutput("async_rst_ready", 32'(tx_ready_a), 32'd1);
    checkOutput("async_rst_cnt", 32'(cnt_a), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(1, 8'h3C, 1, 2'b01, 0, 0, 8'h00, 0, 0);
    stepCycle();
    checkOutput("post_rst_valid", 32'(par_valid_a), 32'd1);
    checkOutput("post_rst_bit", 32'(par_bit_a), 32'd1);
    applyStimulus(0, 8'h00, 1, 2'b01, 1, 0, 8'h00, 0, 0);
    stepCycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(logic'($urandom_range(0, 1)), 8'($urandom), logic'($urandom_range(0, 4) != 0),
                    2'($urandom), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                    8'($urandom), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) == 0));
      stepCycle();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
